// File: rtl/vmsu_pkg.sv
// Shared types and constants for the multiply-accumulate result stage.
package vmsu_pkg;

  localparam int unsigned ACC_W_DEF = 24;
  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned P_W       = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  localparam logic [ACC_W_DEF-1:0] S_MAX_DEF = {1'b0, {(ACC_W_DEF-1){1'b1}}};
  localparam logic [ACC_W_DEF-1:0] S_MIN_DEF = {1'b1, {(ACC_W_DEF-1){1'b0}}};
  localparam logic [ACC_W_DEF-1:0] U_MAX_DEF = {ACC_W_DEF{1'b1}};

  // Saturation limits for an arbitrary accumulator width (w <= 32), as raw bit patterns.
  function automatic logic [31:0] sat_s_max(input int unsigned w);
    logic [32:0] t;
    t = (33'd1 << (w - 1)) - 33'd1;
    return t[31:0];
  endfunction

  function automatic logic [31:0] sat_s_min(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

  function automatic logic [31:0] sat_u_max(input int unsigned w);
    logic [32:0] t;
    t = (33'd1 << w) - 33'd1;
    return t[31:0];
  endfunction

endpackage

// File: rtl/vmsu_sat_add.sv
// Extends a 16-bit product, adds it to the accumulator and clamps on overflow.
module vmsu_sat_add
  import vmsu_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0] i_acc,
  input  logic [P_W-1:0]   i_p,
  input  logic             i_sgn,
  input  logic             i_first,
  output logic [ACC_W-1:0] o_sum_c,
  output logic             o_clamp_c
);

  localparam logic [31:0] L_SMAX32 = sat_s_max(ACC_W);
  localparam logic [31:0] L_SMIN32 = sat_s_min(ACC_W);
  localparam logic [31:0] L_UMAX32 = sat_u_max(ACC_W);
  localparam logic [ACC_W-1:0] L_SMAX = L_SMAX32[ACC_W-1:0];
  localparam logic [ACC_W-1:0] L_SMIN = L_SMIN32[ACC_W-1:0];
  localparam logic [ACC_W-1:0] L_UMAX = L_UMAX32[ACC_W-1:0];

  logic [ACC_W-1:0] w_base;
  logic [ACC_W-1:0] w_ext;
  logic [ACC_W:0]   w_raw;

  // First beat of a frame starts from zero; a 16-bit term can never clamp there.
  always_comb begin
    w_base    = i_first ? '0 : i_acc;
    w_ext     = i_sgn ? {{(ACC_W-P_W){i_p[P_W-1]}}, i_p} : {{(ACC_W-P_W){1'b0}}, i_p};
    w_raw     = i_sgn ? ({w_base[ACC_W-1], w_base} + {w_ext[ACC_W-1], w_ext})
                      : ({1'b0, w_base} + {1'b0, w_ext});
    o_sum_c   = w_raw[ACC_W-1:0];
    o_clamp_c = 1'b0;
    if (i_sgn) begin
      if (w_raw[ACC_W] != w_raw[ACC_W-1]) begin
        o_clamp_c = 1'b1;
        o_sum_c   = w_raw[ACC_W] ? L_SMIN : L_SMAX;
      end
    end else if (w_raw[ACC_W]) begin
      o_clamp_c = 1'b1;
      o_sum_c   = L_UMAX;
    end
  end

endmodule

// File: rtl/vmsu_acc.sv
// Frame accumulator: sums 16-bit products with saturation and holds the result
// until the consumer takes it.
module vmsu_acc
  import vmsu_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [P_W-1:0]   p_in,
  input  logic             mode,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [CNT_W-1:0] cnt_out,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  state_e           r_state, w_state_nxt;
  logic [ACC_W-1:0] r_acc, w_acc_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic             r_mode, w_mode_nxt;
  logic             r_out_valid, w_out_valid_nxt;

  logic             w_in_ready;
  logic             w_beat;
  logic             w_first;
  logic             w_sgn;
  logic [ACC_W-1:0] w_sum;
  logic             w_clamp;

  // Ready is a decode of the state register, forced low while reset is held.
  assign w_in_ready = (r_state != ST_HOLD) && !rst;
  assign w_beat     = in_valid && w_in_ready;
  assign w_first    = (r_state == ST_IDLE);
  assign w_sgn      = w_first ? mode : r_mode;

  vmsu_sat_add #(
    .ACC_W (ACC_W)
  ) u_sat_add (
    .i_acc     (r_acc),
    .i_p       (p_in),
    .i_sgn     (w_sgn),
    .i_first   (w_first),
    .o_sum_c   (w_sum),
    .o_clamp_c (w_clamp)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_ovf_nxt   = r_ovf;
    w_mode_nxt  = r_mode;
    unique case (r_state)
      ST_IDLE: begin
        if (w_beat) begin
          w_acc_nxt   = w_sum;
          w_cnt_nxt   = CNT_W'(1);
          w_ovf_nxt   = 1'b0;
          w_mode_nxt  = mode;
          w_state_nxt = in_last ? ST_HOLD : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (w_beat) begin
          w_acc_nxt   = w_sum;
          w_cnt_nxt   = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
          w_ovf_nxt   = r_ovf | w_clamp;
          w_state_nxt = in_last ? ST_HOLD : ST_ACCUM;
        end
      end
      ST_HOLD: begin
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_out_valid_nxt = (w_state_nxt == ST_HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_mode      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ovf       <= w_ovf_nxt;
      r_mode      <= w_mode_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  assign in_ready  = w_in_ready;
  assign acc_out   = r_acc;
  assign cnt_out   = r_cnt;
  assign ovf       = r_ovf;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_vmsu_acc.sv
// Directed and randomized checks of vmsu_acc against an integer reference model.
module tb_vmsu_acc;

  localparam int unsigned ACC_W = 24;
  localparam int unsigned CNT_W = 16;
  localparam longint S_MAX = (longint'(1) << (ACC_W - 1)) - 1;
  localparam longint S_MIN = -(longint'(1) << (ACC_W - 1));
  localparam longint U_MAX = (longint'(1) << ACC_W) - 1;
  localparam int     C_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [15:0]      p_in;
  logic             mode;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [ACC_W-1:0] acc_out;
  logic [CNT_W-1:0] cnt_out;
  logic             ovf;
  logic             out_valid;
  logic             out_ready;

  int checks = 0;
  int errors = 0;

  // Reference model: the true mathematical running sum, clamped to the frame's range.
  longint m_acc;
  int     m_cnt;
  bit     m_ovf;
  bit     m_mode;
  bit     m_first;

  vmsu_acc #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .p_in      (p_in),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .acc_out   (acc_out),
    .cnt_out   (cnt_out),
    .ovf       (ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic longint ext(input logic [15:0] p, input bit s);
    longint v;
    v = longint'(p);
    if (s && p[15]) v = v - 65536;
    return v;
  endfunction

  function automatic logic [ACC_W-1:0] exp_acc();
    return ACC_W'(m_acc);
  endfunction

  task automatic model_beat(input logic [15:0] p, input bit m);
    longint v;
    if (m_first) begin
      m_mode  = m;
      m_acc   = ext(p, m);
      m_cnt   = 1;
      m_ovf   = 1'b0;
      m_first = 1'b0;
    end else begin
      v = m_acc + ext(p, m_mode);
      if (m_mode) begin
        if (v > S_MAX) begin v = S_MAX; m_ovf = 1'b1; end
        else if (v < S_MIN) begin v = S_MIN; m_ovf = 1'b1; end
      end else if (v > U_MAX) begin
        v = U_MAX; m_ovf = 1'b1;
      end
      m_acc = v;
      if (m_cnt < C_MAX) m_cnt++;
    end
  endtask

  task automatic chk_live(input string tag);
    chk({tag, ".acc"}, 64'(acc_out), 64'(exp_acc()));
    chk({tag, ".cnt"}, 64'(cnt_out), 64'(m_cnt));
    chk({tag, ".ovf"}, 64'(ovf), 64'(m_ovf));
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b1;
    p_in     = 16'($urandom);
    #1;
    chk("rst.in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rst.in_ready_held", 64'(in_ready), 64'd0);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.acc", 64'(acc_out), 64'd0);
    chk("rst.cnt", 64'(cnt_out), 64'd0);
    chk("rst.ovf", 64'(ovf), 64'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    m_acc = 0; m_cnt = 0; m_ovf = 1'b0; m_mode = 1'b0; m_first = 1'b1;
    #1;
    chk("rst.in_ready_after", 64'(in_ready), 64'd1);
  endtask

  task automatic beat(input logic [15:0] p, input bit m, input bit last);
    chk("beat.in_ready", 64'(in_ready), 64'd1);
    in_valid  = 1'b1;
    p_in      = p;
    mode      = m;
    in_last   = last;
    out_ready = 1'($urandom);
    @(posedge clk);
    model_beat(p, m);
    #1;
    in_valid = 1'b0;
    in_last  = 1'($urandom);
    mode     = 1'($urandom);
    p_in     = 16'($urandom);
    @(negedge clk);
    chk_live("beat");
    chk("beat.out_valid", 64'(out_valid), 64'(last));
  endtask

  task automatic gap();
    in_valid = 1'b0;
    p_in     = 16'($urandom);
    in_last  = 1'($urandom);
    @(posedge clk);
    @(negedge clk);
    chk_live("gap");
    chk("gap.out_valid", 64'(out_valid), 64'd0);
  endtask

  task automatic drain(input int stall);
    chk("hold.out_valid", 64'(out_valid), 64'd1);
    chk("hold.in_ready", 64'(in_ready), 64'd0);
    chk_live("hold");
    for (int s = 0; s < stall; s++) begin
      in_valid  = 1'b1;
      p_in      = 16'($urandom);
      in_last   = 1'($urandom);
      out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk_live("stall");
      chk("stall.out_valid", 64'(out_valid), 64'd1);
      chk("stall.in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    p_in      = 16'($urandom);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
    chk("handoff.out_valid", 64'(out_valid), 64'd0);
    chk("handoff.in_ready", 64'(in_ready), 64'd1);
    chk_live("handoff");
    m_first = 1'b1;
  endtask

  function automatic logic [15:0] pick_p();
    case ($urandom_range(0, 5))
      0: return 16'hFFFF;
      1: return 16'h8000;
      2: return 16'h7FFF;
      3: return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int len;
    bit fm;
    rst = 1'b1; p_in = '0; mode = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    do_reset();

    // Unsigned frame
    beat(16'hFFFF, 1'b0, 1'b0);
    beat(16'hFFFF, 1'b1, 1'b0);
    beat(16'h0001, 1'b0, 1'b1);
    chk("u3.acc", 64'(acc_out), 64'h01FFFF);
    chk("u3.cnt", 64'(cnt_out), 64'd3);
    chk("u3.ovf", 64'(ovf), 64'd0);
    drain(2);

    // Signed frames
    beat(16'hFF00, 1'b1, 1'b0);
    beat(16'h0100, 1'b0, 1'b0);
    beat(16'hFFFF, 1'b0, 1'b1);
    chk("s3.acc", 64'(acc_out), 64'hFFFFFF);
    chk("s3.cnt", 64'(cnt_out), 64'd3);
    chk("s3.ovf", 64'(ovf), 64'd0);
    drain(0);
    beat(16'h8000, 1'b1, 1'b1);
    chk("s1.acc", 64'(acc_out), 64'hFF8000);
    chk("s1.cnt", 64'(cnt_out), 64'd1);
    drain(1);

    // Unsigned saturation
    for (int i = 0; i < 257; i++) begin
      beat(16'hFFFF, 1'b0, i == 256);
      if (i == 255) begin
        chk("usat256.acc", 64'(acc_out), 64'hFFFF00);
        chk("usat256.ovf", 64'(ovf), 64'd0);
      end
    end
    chk("usat.acc", 64'(acc_out), 64'hFFFFFF);
    chk("usat.ovf", 64'(ovf), 64'd1);
    chk("usat.cnt", 64'(cnt_out), 64'd257);
    drain(0);

    // Signed saturation, then ovf clears on next frame's first beat
    for (int i = 0; i < 300; i++) beat(16'h8000, 1'b1, i == 299);
    chk("ssat.acc", 64'(acc_out), 64'h800000);
    chk("ssat.ovf", 64'(ovf), 64'd1);
    drain(0);
    beat(16'h0005, 1'b0, 1'b1);
    chk("ssat.next_ovf", 64'(ovf), 64'd0);
    drain(0);

    // Backpressure
    beat(16'h0010, 1'b0, 1'b0);
    gap();
    beat(16'h0020, 1'b0, 1'b1);
    drain(5);
    beat(16'h0003, 1'b0, 1'b1);
    chk("bp.next.acc", 64'(acc_out), 64'h000003);
    drain(0);

    // Reset mid-frame and with a pending result
    beat(16'h1234, 1'b0, 1'b0);
    beat(16'h1111, 1'b0, 1'b0);
    do_reset();
    beat(16'h0005, 1'b0, 1'b1);
    chk("rstmid.acc", 64'(acc_out), 64'h000005);
    chk("rstmid.cnt", 64'(cnt_out), 64'd1);
    do_reset();

    // Randomized frames
    for (int f = 0; f < 40; f++) begin
      fm  = 1'($urandom);
      len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 300)) : int'($urandom_range(1, 12));
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) gap();
        beat(pick_p(), (b == 0) ? fm : 1'($urandom), b == len - 1);
      end
      drain(int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vmsu_acc.md
VMSU_ACC -- requirements
Module: vmsu_acc

Interface
REQ-001 SHALL have parameter ACC_W, default 24, accumulator width in bits (legal range 17..32).
REQ-002 SHALL have parameter CNT_W, default 16, beat-counter width in bits.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port p_in, input, 16, product from the signed/unsigned 8-bit multiplier stage.
REQ-006 SHALL have port mode, input, 1, 1 = signed (two's complement) product, 0 = unsigned.
REQ-007 SHALL have port in_valid, input, 1, p_in/mode/in_last are valid this cycle.
REQ-008 SHALL have port in_last, input, 1, the current beat is the final term of the frame.
REQ-009 SHALL have port in_ready, output, 1, block accepts a beat this cycle.
REQ-010 SHALL have port acc_out, output, ACC_W, accumulated frame result.
REQ-011 SHALL have port cnt_out, output, CNT_W, number of beats accepted in the frame.
REQ-012 SHALL have port ovf, output, 1, sticky saturation flag for the frame.
REQ-013 SHALL have port out_valid, output, 1, acc_out/cnt_out/ovf hold a completed frame.
REQ-014 SHALL have port out_ready, input, 1, consumer accepts the result.

Function
REQ-015 SHALL implement a 3-state FSM: IDLE, ACCUM, HOLD.
REQ-016 Beat accepted SHALL mean in_valid & in_ready on a rising clk edge.
REQ-017 in_ready SHALL be 1 in IDLE and ACCUM and 0 in HOLD.
REQ-018 IDLE, beat accepted: acc <= ext(p_in); cnt <= 1; ovf <= 0; mode latched; next state ACCUM, or HOLD if in_last=1.
REQ-019 ACCUM, beat accepted: acc <= sat(acc + ext(p_in)); cnt <= cnt+1, saturating at all-ones; next state HOLD if in_last=1, else ACCUM.
REQ-020 ext() SHALL sign-extend p_in to ACC_W when the latched mode is 1 and zero-extend it when 0; the mode input on non-first beats SHALL be ignored.
REQ-021 Signed saturation SHALL clamp to 2^(ACC_W-1)-1 or -2^(ACC_W-1); unsigned saturation SHALL clamp to 2^ACC_W-1.
REQ-022 ovf SHALL be set on any clamp and hold until the next frame's first beat.
REQ-023 out_valid SHALL be 1 exactly in HOLD, the cycle after the in_last beat is accepted (1-cycle latency).
REQ-024 In HOLD, acc_out, cnt_out and ovf SHALL remain stable until out_valid & out_ready, then the FSM SHALL go to IDLE.
REQ-025 A beat presented in the same cycle as the HOLD->IDLE handoff SHALL NOT be accepted; it is taken from the following cycle.
REQ-026 Cycles with in_valid=0 in ACCUM SHALL leave all state unchanged.
REQ-027 acc_out and cnt_out SHALL reflect the live accumulator in every state (meaningful only when out_valid=1).

Reset
REQ-028 On rst=1 at a clk edge: state <= IDLE; acc_out, cnt_out and ovf <= 0; out_valid <= 0; the latched mode <= 0.
REQ-029 rst SHALL override all in-flight activity, including a frame in ACCUM and a result pending in HOLD; the partial frame is discarded.
REQ-030 While rst=1, in_ready SHALL be driven 0.

Structure
REQ-031 Package vmsu_pkg SHALL hold the FSM state enum, default ACC_W/CNT_W, and the signed/unsigned saturation limit constants.
REQ-032 SHALL contain one combinational sub-module, vmsu_sat_add, which performs extension, addition, saturation and the clamp flag; the FSM and registers SHALL reside in vmsu_acc.

Verification
REQ-033 Unsigned frame: mode=0, beats 0xFFFF, 0xFFFF, 0x0001 (last) -> acc_out=0x01FFFF, cnt_out=3, ovf=0, out_valid one cycle after the last beat.
REQ-034 Signed frame: mode=1, beats 0xFF00, 0x0100, 0xFFFF (last) -> acc_out=0xFFFFFF, cnt_out=3, ovf=0; a single-beat frame of 0x8000 -> acc_out=0xFF8000, cnt_out=1.
REQ-035 Unsigned saturation: 257 beats of 0xFFFF -> after 256 beats acc=0xFFFF00, ovf=0; final acc_out=0xFFFFFF, ovf=1, cnt_out=257.
REQ-036 Signed saturation: 300 beats of 0x8000 -> acc_out=0x800000, ovf=1; the next frame's first beat clears ovf to 0.
REQ-037 Backpressure: out_ready=0 for 5 cycles in HOLD with in_valid=1 -> in_ready=0, outputs stable, no beat consumed; out_ready=1 -> IDLE, next beat accepted the cycle after.
REQ-038 Reset mid-frame: rst pulse after 2 beats -> out_valid=0, acc_out=0, cnt_out=0; next frame of 0x0005 (last) -> acc_out=0x000005, cnt_out=1.
